// File: rtl/writeback_unit.sv
// Register file write-side front end: ALU result writes, aligned data loads
// with byte/half extraction and extension, and x0 write suppression.
`timescale 1ns/1ps
module writeback_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_valid,
   output logic            wb_ready,
   input  logic [4:0]      wb_rd,
   input  logic            wb_is_load,
   input  logic [2:0]      wb_funct3,
   input  logic [XLEN-1:0] wb_result,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            regWrite,
   output logic [4:0]      writeRegister,
   output logic [XLEN-1:0] writeData,
   output logic            load_fault
);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t          state;
   logic [4:0]      ld_rd;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_off;
   logic            fault;
   logic [7:0]      sel_byte;
   logic [15:0]     sel_half;
   logic [XLEN-1:0] load_data;

   assign wb_ready = (state == IDLE);

   // Misaligned halves/words and unused funct3 encodings are rejected up front.
   always_comb begin
      fault = 1'b0;
      case (wb_funct3)
         3'b000, 3'b100: fault = 1'b0;
         3'b001, 3'b101: fault = wb_result[0];
         3'b010:         fault = (wb_result[1:0] != 2'b00);
         default:        fault = 1'b1;
      endcase
   end

   always_comb begin
      sel_byte = mem_rdata[7:0];
      case (ld_off)
         2'd0: sel_byte = mem_rdata[7:0];
         2'd1: sel_byte = mem_rdata[15:8];
         2'd2: sel_byte = mem_rdata[23:16];
         2'd3: sel_byte = mem_rdata[31:24];
      endcase
      sel_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_funct3)
         3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
         3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         regWrite      <= 1'b0;
         mem_req       <= 1'b0;
         load_fault    <= 1'b0;
         mem_addr      <= '0;
         writeRegister <= '0;
         writeData     <= '0;
         ld_rd         <= '0;
         ld_funct3     <= '0;
         ld_off        <= '0;
      end else begin
         regWrite   <= 1'b0;
         load_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (wb_valid) begin
                  if (!wb_is_load) begin
                     if (wb_rd != 5'd0) begin
                        regWrite      <= 1'b1;
                        writeRegister <= wb_rd;
                        writeData     <= wb_result;
                     end
                  end else if (fault) begin
                     load_fault <= 1'b1;
                  end else begin
                     ld_rd     <= wb_rd;
                     ld_funct3 <= wb_funct3;
                     ld_off    <= wb_result[1:0];
                     mem_req   <= 1'b1;
                     mem_addr  <= {wb_result[XLEN-1:2], 2'b00};
                     state     <= WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
                  // rd = 0 loads still complete the read; only the write is dropped.
                  if (ld_rd != 5'd0) begin
                     regWrite      <= 1'b1;
                     writeRegister <= ld_rd;
                     writeData     <= load_data;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: driver pushes expectations, a negedge
// monitor pops and compares whenever the DUT produces a write, fault or request.
`timescale 1ns/1ps
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic [4:0]  wb_rd = '0;
   logic        wb_is_load = 1'b0;
   logic [2:0]  wb_funct3 = '0;
   logic [31:0] wb_result = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic        load_fault;

   writeback_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_rd(wb_rd), .wb_is_load(wb_is_load), .wb_funct3(wb_funct3),
      .wb_result(wb_result), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .regWrite(regWrite),
      .writeRegister(writeRegister), .writeData(writeData), .load_fault(load_fault)
   );

   always #5 clk = ~clk;

   typedef struct { logic [4:0] rd; logic [31:0] data; bit is_load; int acc; } wr_t;
   typedef struct { logic [31:0] addr; int acc; } req_t;

   wr_t  exp_wr[$];
   req_t exp_req[$];
   int   exp_flt[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [31:0] mem [256];
   int ack_delay = 0;
   int wait_cnt = 0;
   bit force_ack = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic miss(input string name, input string what);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Reference model: load legality and little-endian extraction with extension.
   function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return a[0];
         3'b010:         return a[1:0] != 2'b00;
         default:        return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * int'(a[1:0]));
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b100:  return {24'h0, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory responder: acks after ack_delay wait cycles, random data otherwise.
   always @(posedge clk) begin
      #2;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (force_ack) begin
         mem_ack = 1'b1;
      end else if (mem_req && !reset) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[9:2]];
            wait_cnt  = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Monitor
   bit          prev_req = 1'b0;
   logic [31:0] cur_addr = '0;
   int          ack_cyc = -10;

   always @(negedge clk) begin
      if (reset) begin
         prev_req = 1'b0;
      end else begin
         if (mem_req) begin
            if (!prev_req) begin
               if (exp_req.size() == 0) begin
                  miss("unexpected_mem_req", $sformatf("got request at 0x%08h, none expected", mem_addr));
                  cur_addr = mem_addr;
               end else begin
                  req_t r;
                  r = exp_req.pop_front();
                  cur_addr = r.addr;
                  check("mem_req_latency", cyc, r.acc + 1);
               end
            end
            check("mem_addr", mem_addr, cur_addr);
            check("wb_ready_wait", {31'b0, wb_ready}, 32'd0);
            if (mem_ack) ack_cyc = cyc;
         end
         if (regWrite) begin
            if (exp_wr.size() == 0) begin
               miss("unexpected_write", $sformatf("got x%0d <= 0x%08h, none expected", writeRegister, writeData));
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               check("write_rd", {27'b0, writeRegister}, {27'b0, e.rd});
               check("write_data", writeData, e.data);
               check(e.is_load ? "load_write_latency" : "alu_write_latency",
                     cyc, e.is_load ? ack_cyc + 1 : e.acc + 1);
            end
         end
         if (load_fault) begin
            if (exp_flt.size() == 0) begin
               miss("unexpected_fault", "load_fault pulsed, none expected");
            end else begin
               int a;
               a = exp_flt.pop_front();
               check("fault_latency", cyc, a + 1);
            end
         end
         prev_req = mem_req;
      end
   end

   task automatic issue(input logic [4:0] rd, input bit ld, input logic [2:0] f3,
                        input logic [31:0] v, input bit exp_f, input logic [31:0] exp_d,
                        output int stall);
      int acc;
      wb_valid   = 1'b1;
      wb_rd      = rd;
      wb_is_load = ld;
      wb_funct3  = f3;
      wb_result  = v;
      stall      = 0;
      while (1) begin
         @(negedge clk);
         if (wb_ready) break;
         stall++;
         if (stall > 64) begin
            miss("accept_timeout", "wb_ready stayed low for 64 cycles");
            wb_valid = 1'b0;
            return;
         end
      end
      acc = cyc;
      if (!ld) begin
         if (rd != 5'd0) exp_wr.push_back('{rd: rd, data: v, is_load: 1'b0, acc: acc});
      end else if (exp_f) begin
         exp_flt.push_back(acc);
      end else begin
         exp_req.push_back('{addr: {v[31:2], 2'b00}, acc: acc});
         if (rd != 5'd0) exp_wr.push_back('{rd: rd, data: exp_d, is_load: 1'b1, acc: acc});
      end
      @(posedge clk);
      #1;
      wb_valid   = 1'b0;
      wb_rd      = 5'($urandom);
      wb_is_load = 1'($urandom);
      wb_funct3  = 3'($urandom);
      wb_result  = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_regWrite", {31'b0, regWrite}, 32'd0);
      check("reset_mem_req", {31'b0, mem_req}, 32'd0);
      check("reset_load_fault", {31'b0, load_fault}, 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_writeRegister", {27'b0, writeRegister}, 32'd0);
      check("reset_writeData", writeData, 32'd0);
      check("reset_wb_ready", {31'b0, wb_ready}, 32'd1);
      @(posedge clk);
      #1;

      // back-to-back ALU writes
      issue(5'd5, 1'b0, 3'b000, 32'h0000_1234, 1'b0, 32'h0, st);
      issue(5'd6, 1'b0, 3'b000, 32'hFFFF_FFFF, 1'b0, 32'h0, st);

      // x0 suppression
      issue(5'd0, 1'b0, 3'b000, 32'h0000_DEAD, 1'b0, 32'h0, st);
      issue(5'd0, 1'b1, 3'b010, 32'h0000_0100, 1'b0, 32'h0, st);
      idle(3);

      // load extension, 3 wait cycles
      mem[8'h80] = 32'h80F0_7F81;
      ack_delay = 3;
      issue(5'd7,  1'b1, 3'b000, 32'h0000_0203, 1'b0, 32'hFFFF_FF80, st);
      issue(5'd8,  1'b1, 3'b100, 32'h0000_0200, 1'b0, 32'h0000_0081, st);
      issue(5'd9,  1'b1, 3'b001, 32'h0000_0202, 1'b0, 32'hFFFF_80F0, st);
      issue(5'd10, 1'b1, 3'b101, 32'h0000_0200, 1'b0, 32'h0000_7F81, st);
      issue(5'd11, 1'b1, 3'b010, 32'h0000_0200, 1'b0, 32'h80F0_7F81, st);
      idle(6);

      // faults
      issue(5'd12, 1'b1, 3'b010, 32'h0000_0102, 1'b1, 32'h0, st);
      check("fault_lw_ready", st, 0);
      issue(5'd12, 1'b1, 3'b001, 32'h0000_0101, 1'b1, 32'h0, st);
      check("fault_lh_ready", st, 0);
      issue(5'd12, 1'b1, 3'b011, 32'h0000_0100, 1'b1, 32'h0, st);
      check("fault_f3_ready", st, 0);
      idle(2);

      // backpressure: load with 5 wait cycles, ALU op held behind it
      ack_delay = 5;
      issue(5'd13, 1'b1, 3'b010, 32'h0000_0200, 1'b0, 32'h80F0_7F81, st);
      issue(5'd14, 1'b0, 3'b000, 32'h0000_CAFE, 1'b0, 32'h0, st);
      check("backpressure_stall", st, 6);
      idle(3);

      // reset two cycles after a load accept, then stray acks
      ack_delay = 20;
      issue(5'd15, 1'b1, 3'b010, 32'h0000_0200, 1'b0, 32'h80F0_7F81, st);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      exp_wr.delete();
      @(negedge clk);
      check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mid_wb_ready", {31'b0, wb_ready}, 32'd1);
      check("rst_mid_regWrite", {31'b0, regWrite}, 32'd0);
      force_ack = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      force_ack = 1'b0;
      idle(2);
      @(negedge clk);
      check("stray_ack_mem_req", {31'b0, mem_req}, 32'd0);
      check("stray_ack_wb_ready", {31'b0, wb_ready}, 32'd1);
      @(posedge clk);
      #1;

      // randomized stream against the reference model
      for (int i = 0; i < 300; i++) begin
         logic [4:0]  rd;
         logic [2:0]  f3;
         logic [31:0] v;
         bit          ld;
         rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ld = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         v  = $urandom;
         ack_delay = $urandom_range(0, 4);
         issue(rd, ld, f3, v, is_fault(f3, v), load_value(f3, v, mem[v[9:2]]), st);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(12);

      check("drain_writes", exp_wr.size(), 0);
      check("drain_requests", exp_req.size(), 0);
      check("drain_faults", exp_flt.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
